iter_divider: RTL and testbench
===============================

# iter_divider

Iterative unsigned restoring divider for the arithmetic functional units of the Tomasulo core. Accepts one tagged dividend/divisor pair through a valid/ready handshake. Produces quotient and remainder one bit per cycle, using subtract-and-restore steps. Returns the tagged result to the common-data-bus arbiter through a second valid/ready handshake. Divide-by-zero is flagged, not trapped.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- TAG_W, 4, reservation-station tag width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous abort of any in-flight or pending operation (mispredict recovery)
- in_valid  input  1  request present
- in_ready  output  1  divider can accept a request this cycle
- in_tag  input  TAG_W  tag of issuing reservation station
- in_dividend  input  WIDTH  unsigned dividend
- in_divisor  input  WIDTH  unsigned divisor
- out_valid  output  1  result present
- out_ready  input  1  CDB arbiter consumes result this cycle
- out_tag  output  TAG_W  tag of result
- out_quotient  output  WIDTH  quotient
- out_remainder  output  WIDTH  remainder
- out_div_by_zero  output  1  divisor was zero

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. If in_valid, latch tag, dividend (quotient shift register) and divisor. Clear the partial remainder, load count=WIDTH-1 and go to BUSY.
- BUSY: in_ready=0. Each cycle, one restoring step:
  - t = {rem[WIDTH-1:0], q[WIDTH-1]}, WIDTH+1 bits.
  - d = t − {1'b0, divisor}, WIDTH+1 bits.
  - If d's MSB is 0: rem ← d[WIDTH-1:0] and shift 1 into q. Otherwise rem ← t[WIDTH-1:0] and shift 0 into q.
  - q shifts left one bit per step.
  - When count==0, the last step completes and the state goes to DONE. Otherwise count decrements.
- DONE: out_valid=1 and outputs hold stable. If out_ready, go to IDLE. No new request is accepted in DONE, so in_ready=0.
- Divisor 0: the algorithm runs unmodified and yields quotient all-ones and remainder = dividend. out_div_by_zero is latched at accept as (divisor==0).
- flush: from any state, go to IDLE next cycle, out_valid=0, and discard the result. A flush coincident with an in_valid in IDLE does not accept the request.
- reset has priority over flush and produces the same state effect as flush. All datapath registers clear to 0.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_tag=0, out_quotient=0, out_remainder=0, out_div_by_zero=0.
- Accept in cycle N (in_valid & in_ready at edge N). out_valid rises after edge N+WIDTH, so latency is WIDTH+1 cycles from accept to first result-visible cycle.
- Result handshake completes at the edge where out_valid & out_ready. in_ready is 1 in the following cycle.
- Minimum issue interval: WIDTH+2 cycles with out_ready held high.
- While out_valid=1 and out_ready=0, all out_* hold constant indefinitely.
- Outputs are registered; no combinational path from in_* or out_ready to out_*.
- in_ready depends on state only, not on in_valid.

## Structure
- Shared package arith_pkg:
  - state enum {IDLE, BUSY, DONE}.
  - Default WIDTH/TAG_W constants.
  - clog2-based count width.
- Sub-module restoring_div_step: combinational, one step. Inputs rem, q_msb, divisor. Outputs next_rem, q_bit. Built on a (WIDTH+1)-bit ripple subtractor of full-adder cells with inverted B and carry-in 1.
- Top holds the FSM, counter, shift registers and handshake logic.

## Test plan
- Reset, then 100 / 7 accepted at cycle 0 with tag 3, out_ready=1. Required: out_valid first high at cycle 33 (WIDTH=32) with q=14, r=2, tag=3, div_by_zero=0.
- 0x00001234 / 0. Required: q=0xFFFFFFFF, r=0x00001234, div_by_zero=1, same latency.
- 0xFFFFFFFF / 1 and 5 / 9. Required: q=0xFFFFFFFF, r=0 for the first; q=0, r=5 for the second.
- out_ready held low 10 cycles after out_valid. Required: outputs stable and in_ready=0 throughout. Release out_ready: in_ready=1 next cycle and a back-to-back request is accepted.
- flush asserted mid-BUSY (cycle 10). Required: IDLE next cycle, no out_valid for that op. Then 50 / 5 yields q=10, r=0.
- reset asserted in DONE while out_ready=0. Required: out_valid=0 and all outputs 0 next cycle, in_ready=1.

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared types and sizing helpers for the iterative arithmetic units
package arith_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_TAG_W = 4;
    function automatic int cnt_w(input int w);
        return $clog2(w);
    endfunction
endpackage

// File: rtl/restoring_div_step.sv
// restoring_div_step: one combinational subtract-and-restore division step
module restoring_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);
    logic [WIDTH:0] t, b, s;
    logic [WIDTH:0] c;
    assign t = {rem, q_msb};
    assign b = ~{1'b0, divisor};
    assign c[0] = 1'b1;
    for (genvar i = 0; i <= WIDTH; i++) begin : g_sum
        assign s[i] = t[i] ^ b[i] ^ c[i];
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign c[i+1] = (t[i] & b[i]) | (c[i] & (t[i] ^ b[i]));
    end
    assign q_bit    = ~s[WIDTH];
    assign next_rem = q_bit ? s[WIDTH-1:0] : t[WIDTH-1:0];
endmodule

// File: rtl/iter_divider.sv
// iter_divider: iterative restoring unsigned divider with tagged valid/ready handshakes
module iter_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_by_zero
);
    localparam int CW = cnt_w(WIDTH);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [WIDTH-1:0] q_q, q_d, rem_q, rem_d, dvs_q, dvs_d;
    logic dbz_q, dbz_d;
    logic [WIDTH-1:0] step_rem;
    logic step_bit;

    restoring_div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem_q),
        .q_msb   (q_q[WIDTH-1]),
        .divisor (dvs_q),
        .next_rem(step_rem),
        .q_bit   (step_bit)
    );

    assign in_ready        = state_q == IDLE;
    assign out_valid       = state_q == DONE;
    assign out_tag         = tag_q;
    assign out_quotient    = q_q;
    assign out_remainder   = rem_q;
    assign out_div_by_zero = dbz_q;

    // next state: flush aborts everything, otherwise accept / step / hand off
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        q_d     = q_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        dbz_d   = dbz_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    state_d = BUSY;
                    tag_d   = in_tag;
                    q_d     = in_dividend;
                    dvs_d   = in_divisor;
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    dbz_d   = in_divisor == '0;
                end
                BUSY: begin
                    rem_d   = step_rem;
                    q_d     = {q_q[WIDTH-2:0], step_bit};
                    cnt_d   = cnt_q - 1'b1;
                    state_d = cnt_q == '0 ? DONE : BUSY;
                end
                DONE: state_d = out_ready ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // state and datapath registers, all cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            q_q     <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: vector, corner-case and randomized checks of iter_divider
module tb_iter_divider;
    localparam int W = 32;
    logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [3:0] in_tag = 0;
    logic [W-1:0] in_dividend = 0, in_divisor = 0;
    logic in_ready, out_valid, out_div_by_zero;
    logic [3:0] out_tag;
    logic [W-1:0] out_quotient, out_remainder;
    int n_pass = 0, n_tot = 0;

    iter_divider #(.WIDTH(W), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_div_by_zero(out_div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   tag;
        logic [W-1:0] a, b, q, r;
        logic         z;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h want %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic issue(input logic [3:0] tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int k = 0;
        while (!in_ready && k < 200) begin @(negedge clk); k++; end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1; in_tag = tag; in_dividend = a; in_divisor = b;
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    endtask

    task automatic run_op(input logic [3:0] tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r, input logic z, input int hold);
        int lat;
        issue(tag, a, b);
        wait_valid(lat);
        chk("latency", 32'(lat), 32'(W + 1));
        chk("tag", 32'(out_tag), 32'(tag));
        chk("quotient", out_quotient, q);
        chk("remainder", out_remainder, r);
        chk("div_by_zero", 32'(out_div_by_zero), 32'(z));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_quotient", out_quotient, q);
            chk("hold_remainder", out_remainder, r);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_out_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat, seen;
        logic [W-1:0] a, b;
        vecs[0] = '{4'd3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
        vecs[1] = '{4'd1, 32'h00001234, 32'd0, 32'hFFFFFFFF, 32'h00001234, 1'b1};
        vecs[2] = '{4'd5, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0};
        vecs[3] = '{4'd6, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0};
        vecs[4] = '{4'd7, 32'd0, 32'd3, 32'd0, 32'd0, 1'b0};
        vecs[5] = '{4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0};
        vecs[6] = '{4'd9, 32'h80000000, 32'd3, 32'h2AAAAAAA, 32'd2, 1'b0};
        vecs[7] = '{4'd15, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1};
        repeat (2) @(negedge clk);
        reset = 0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        chk("rst_quotient", out_quotient, 32'd0);
        chk("rst_remainder", out_remainder, 32'd0);
        chk("rst_dbz", 32'(out_div_by_zero), 32'd0);
        for (int i = 0; i < 8; i++)
            run_op(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, 0);
        run_op(4'd4, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 10);
        run_op(4'd2, 32'd77, 32'd7, 32'd11, 32'd0, 1'b0, 0);
        issue(4'd9, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        flush = 1; in_valid = 1; in_tag = 4'd11; in_dividend = 32'd9; in_divisor = 32'd2;
        @(negedge clk);
        flush = 0; in_valid = 0;
        chk("flush_idle_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen++; end
        chk("flush_no_result", 32'(seen), 32'd0);
        run_op(4'd2, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 0);
        issue(4'd12, 32'd99, 32'd10);
        wait_valid(lat);
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("done_rst_valid", 32'(out_valid), 32'd0);
        chk("done_rst_in_ready", 32'(in_ready), 32'd1);
        chk("done_rst_tag", 32'(out_tag), 32'd0);
        chk("done_rst_quotient", out_quotient, 32'd0);
        chk("done_rst_remainder", out_remainder, 32'd0);
        chk("done_rst_dbz", 32'(out_div_by_zero), 32'd0);
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom >> $urandom_range(0, 31));
            run_op(4'($urandom_range(0, 15)), a, b,
                   b == 0 ? 32'hFFFFFFFF : a / b, b == 0 ? a : a % b, b == 0, i % 3);
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
